// File: rtl/sram_stream_writer_pkg.sv
// Shared types and geometry for the sky130 1 KB 1rw1r SRAM port wrappers.
// Used by the port-0 stream writer and the port-1 auto-incrementing reader.
package sram_stream_writer_pkg;

    localparam int unsigned SRAM_DATA_WIDTH = 32;
    localparam int unsigned SRAM_ADDR_WIDTH = 8;
    localparam int unsigned SRAM_NUM_WMASKS = SRAM_DATA_WIDTH / 8;
    localparam int unsigned SRAM_DEPTH      = 2 ** SRAM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StFill   = 2'd2
    } state_e;

endpackage

// File: rtl/sram_stream_writer.sv
// Port-0 write sequencer for the 1rw1r SRAM: drains a valid/ready stream or fills a region
// with a constant pattern, issuing one registered write per accepted word.
module sram_stream_writer
    import sram_stream_writer_pkg::*;
#(
    parameter int unsigned NUM_WMASKS = SRAM_NUM_WMASKS,
    parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    input  logic                  cmd_fill,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_pattern,
    input  logic                  abort,

    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [NUM_WMASKS-1:0] s_mask,

    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,

    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH:0]   words_written
);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_cnt_q;
    logic [ADDR_WIDTH:0]     remaining_q;
    logic [DATA_WIDTH-1:0]   pattern_q;
    logic                    has_work;

    // A command stays busy for one extra cycle after its last step so that done and the
    // final write appear while busy is still high.
    assign has_work = (state_q != StIdle) && (remaining_q != '0);
    assign s_ready  = (state_q == StStream) && (remaining_q != '0);
    assign busy     = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_cnt_q    <= '0;
            remaining_q   <= '0;
            pattern_q     <= '0;
            csb0          <= 1'b1;
            web0          <= 1'b1;
            wmask0        <= '0;
            addr0         <= '0;
            din0          <= '0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            words_written <= '0;
        end else begin
            csb0    <= 1'b1;
            web0    <= 1'b1;
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        addr_cnt_q    <= cmd_base;
                        pattern_q     <= cmd_pattern;
                        // Zero length encodes the full depth of the macro.
                        remaining_q   <= (cmd_len == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : cmd_len;
                        words_written <= '0;
                        state_q       <= cmd_fill ? StFill : StStream;
                    end
                end
                StStream, StFill: begin
                    if (!has_work) begin
                        state_q <= StIdle;
                    end else if (abort) begin
                        state_q <= StIdle;
                        aborted <= 1'b1;
                    end else if (state_q == StFill || s_valid) begin
                        csb0          <= 1'b0;
                        web0          <= 1'b0;
                        addr0         <= addr_cnt_q;
                        din0          <= (state_q == StFill) ? pattern_q : s_data;
                        wmask0        <= (state_q == StFill) ? {NUM_WMASKS{1'b1}} : s_mask;
                        addr_cnt_q    <= addr_cnt_q + ADDR_WIDTH'(1);
                        remaining_q   <= remaining_q - (ADDR_WIDTH + 1)'(1);
                        words_written <= words_written + (ADDR_WIDTH + 1)'(1);
                        done          <= (remaining_q == (ADDR_WIDTH + 1)'(1));
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_writer.sv
// Randomized self-checking bench for sram_stream_writer against a command-level model
// plus a behavioural SRAM array for read-back.
module tb_sram_stream_writer;
    import sram_stream_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_fill, abort, s_valid;
    logic [7:0]  cmd_base;
    logic [8:0]  cmd_len;
    logic [31:0] cmd_pattern, s_data;
    logic [3:0]  s_mask;
    logic        s_ready, csb0, web0, busy, done, aborted;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic [8:0]  words_written;

    sram_stream_writer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_fill(cmd_fill), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .cmd_pattern(cmd_pattern), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_mask(s_mask),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .busy(busy), .done(done), .aborted(aborted), .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: port-0 write with byte mask.
    logic [31:0] mem [SRAM_DEPTH];
    always @(posedge clk) begin
        if (!csb0 && !web0) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int aborted_seen = 0;

    // Command-level model state.
    bit          m_active = 0, m_fill = 0, m_pend = 0, m_done = 0, m_abort = 0;
    int          m_base = 0, m_len = 0, m_issued = 0;
    logic [31:0] m_pattern = '0, m_data = '0;
    logic [7:0]  m_addr = '0;
    logic [3:0]  m_mask = '0;

    bit tog [6] = '{1, 0, 1, 1, 0, 1};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: predict from the driven inputs, then compare the pins.
    task automatic tick();
        bit n_pend = 0, n_done = 0, n_abort = 0;
        if (rst) begin
            m_active = 0; m_issued = 0;
            m_addr = '0; m_data = '0; m_mask = '0;
        end else if (!m_active) begin
            if (cmd_valid) begin
                m_active  = 1;
                m_fill    = cmd_fill;
                m_base    = cmd_base;
                m_len     = (cmd_len == 0) ? SRAM_DEPTH : cmd_len;
                m_pattern = cmd_pattern;
                m_issued  = 0;
            end
        end else if (m_issued == m_len) begin
            m_active = 0;
        end else if (abort) begin
            m_active = 0;
            n_abort  = 1;
        end else if (m_fill || s_valid) begin
            n_pend = 1;
            m_addr = 8'((m_base + m_issued) % SRAM_DEPTH);
            m_data = m_fill ? m_pattern : s_data;
            m_mask = m_fill ? 4'hF : s_mask;
            n_done = (m_issued + 1 == m_len);
            m_issued++;
        end
        m_pend = n_pend; m_done = n_done; m_abort = n_abort;
        @(posedge clk);
        #1;
        done_seen    += int'(done);
        aborted_seen += int'(aborted);
        check_eq("csb0", csb0, !m_pend);
        check_eq("web0", web0, !m_pend);
        check_eq("addr0", addr0, m_addr);
        check_eq("din0", din0, m_data);
        check_eq("wmask0", wmask0, m_mask);
        check_eq("done", done, m_done);
        check_eq("aborted", aborted, m_abort);
        check_eq("busy", busy, m_active);
        check_eq("s_ready", s_ready, m_active && !m_fill && (m_issued < m_len));
        check_eq("words_written", words_written, m_issued);
    endtask

    // vmode: 0 = valid held, 1 = toggle pattern, 2 = random valid/mask with junk commands.
    task automatic run_cmd(input bit fill, input int base, input int len, input logic [31:0] pat,
                           input int vmode, input int abort_at, input logic [31:0] dbase);
        int cyc = 0;
        cmd_fill = fill; cmd_base = 8'(base); cmd_len = 9'(len); cmd_pattern = pat;
        cmd_valid = 1; s_valid = 0; abort = 0;
        tick();
        cmd_valid = 0;
        while (m_active && cyc < 2000) begin
            case (vmode)
                0:       s_valid = 1;
                1:       s_valid = tog[cyc % 6];
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = (dbase != 0) ? dbase + 32'(m_issued) : $urandom;
            s_mask = (vmode == 2) ? 4'($urandom) : 4'hF;
            abort  = (abort_at >= 0) && (m_issued == abort_at) && (m_issued < m_len);
            if (vmode == 2) begin
                cmd_valid   = ($urandom_range(0, 3) == 0);
                cmd_fill    = 1'($urandom);
                cmd_base    = 8'($urandom);
                cmd_len     = 9'($urandom);
                cmd_pattern = $urandom;
            end
            tick();
            cyc++;
        end
        check_eq("timeout", m_active, 0);
        cmd_valid = 0; s_valid = 0; abort = 0;
    endtask

    initial begin
        int d0, a0;
        rst = 1; cmd_valid = 0; cmd_fill = 0; cmd_base = '0; cmd_len = '0; cmd_pattern = '0;
        abort = 0; s_valid = 0; s_data = '0; s_mask = '0;
        tick();
        tick();
        rst = 0;
        tick();

        // Directed stream: base 0x10, four words A0..A3.
        d0 = done_seen;
        run_cmd(0, 'h10, 4, 32'h0, 0, -1, 32'hA0);
        for (int i = 0; i < 4; i++) check_eq("stream_mem", mem[8'h10 + 8'(i)], 32'hA0 + 32'(i));
        check_eq("stream_done_cnt", done_seen - d0, 1);
        check_eq("stream_ww", words_written, 4);

        // Toggling valid.
        run_cmd(0, 'h20, 4, 32'h0, 1, -1, 32'hB0);
        for (int i = 0; i < 4; i++) check_eq("toggle_mem", mem[8'h20 + 8'(i)], 32'hB0 + 32'(i));

        // Fill across the address wrap.
        run_cmd(1, 'hFE, 3, 32'hDEADBEEF, 0, -1, 32'h0);
        check_eq("fill_mem_fe", mem[8'hFE], 32'hDEADBEEF);
        check_eq("fill_mem_ff", mem[8'hFF], 32'hDEADBEEF);
        check_eq("fill_mem_00", mem[8'h00], 32'hDEADBEEF);

        // Abort in IDLE is ignored.
        abort = 1;
        tick();
        abort = 0;

        // Full-depth fill from a nonzero base, then read back every word.
        d0 = done_seen;
        run_cmd(1, 'h37, 0, 32'h5A5AC3C3, 0, -1, 32'h0);
        check_eq("full_ww", words_written, 256);
        check_eq("full_done_cnt", done_seen - d0, 1);
        for (int a = 0; a < SRAM_DEPTH; a++) check_eq("full_mem", mem[a], 32'h5A5AC3C3);

        // Abort together with the 4th handshake.
        d0 = done_seen; a0 = aborted_seen;
        run_cmd(0, 'h80, 8, 32'h0, 0, 3, 32'hC0);
        check_eq("abort_ww", words_written, 3);
        check_eq("abort_done_cnt", done_seen - d0, 0);
        check_eq("abort_pulse_cnt", aborted_seen - a0, 1);
        check_eq("abort_unwritten", mem[8'h83], 32'h5A5AC3C3);

        // Reset in the middle of a fill, then a new command straight away.
        cmd_fill = 1; cmd_base = 8'h40; cmd_len = 9'd20; cmd_pattern = 32'h1234_5678;
        cmd_valid = 1;
        tick();
        cmd_valid = 0;
        for (int c = 0; c < 50 && m_issued < 5; c++) tick();
        rst = 1;
        tick();
        rst = 0;
        run_cmd(0, 'hF8, 12, 32'h0, 2, -1, 32'h0);

        // Random commands.
        for (int i = 0; i < 24; i++) begin
            bit fl;
            int ln, ab;
            fl = ($urandom_range(0, 3) == 0);
            ln = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1;
            run_cmd(fl, int'($urandom_range(0, 255)), ln, $urandom, 2, ab, 32'h0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_stream_writer.md
Name: sram_stream_writer

Overview:
- Write-side sequencer for port 0 of the sky130 1 KB 1rw1r SRAM macro.
- Mirrors the auto-incrementing port-1 read path.
- Takes a command (base address, length, mode) and either drains a valid/ready data stream into consecutive SRAM words or fills a region with a constant pattern.
- Drives the macro's active-low chip-select/write-enable directly and reports completion.

Parameters:
- NUM_WMASKS, 4, byte-write mask width (DATA_WIDTH/8).
- DATA_WIDTH, 32, SRAM word width.
- ADDR_WIDTH, 8, SRAM address width; depth = 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock; also the SRAM clk0.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command strobe; sampled only in IDLE.
- cmd_fill  in  1  1 = fill mode, 0 = stream mode.
- cmd_base  in  ADDR_WIDTH  first word address.
- cmd_len  in  ADDR_WIDTH+1  word count; 0 means full depth (2^ADDR_WIDTH).
- cmd_pattern  in  DATA_WIDTH  fill value, captured at command accept.
- abort  in  1  terminate the active command.
- s_valid  in  1  stream data valid.
- s_ready  out  1  stream data ready.
- s_data  in  DATA_WIDTH  stream word.
- s_mask  in  NUM_WMASKS  stream byte mask.
- csb0  out  1  SRAM port-0 chip select, active low.
- web0  out  1  SRAM port-0 write enable, active low.
- wmask0  out  NUM_WMASKS  SRAM byte mask.
- addr0  out  ADDR_WIDTH  SRAM address.
- din0  out  DATA_WIDTH  SRAM write data.
- busy  out  1  high while STREAM or FILL.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort.
- words_written  out  ADDR_WIDTH+1  writes issued by the current or last command.

Behaviour:
- Reset (rst=1 at posedge), from any state including mid-command:
  - state to IDLE.
  - csb0=1, web0=1; wmask0, addr0, din0 = 0.
  - s_ready=0, busy=0, done=0, aborted=0, words_written=0.
  - No write is issued in the reset cycle.
- States: IDLE, STREAM, FILL.
- IDLE, cmd_valid=1:
  - Latch cmd_base into the address counter and cmd_pattern.
  - Latch remaining = (cmd_len==0 ? 2^ADDR_WIDTH : cmd_len); clear words_written.
  - Next state is FILL if cmd_fill, else STREAM.
  - cmd_valid outside IDLE is ignored.
- STREAM:
  - s_ready = (state==STREAM) && remaining>0. It is combinational from state only and never depends on s_valid.
  - Handshake when s_valid && s_ready. The next cycle presents one write: csb0=0, web0=0, addr0=counter, din0=s_data, wmask0=s_mask.
  - The counter increments mod 2^ADDR_WIDTH (wraps 255 to 0 at default); remaining decrements; words_written increments.
  - No handshake means the next cycle has csb0=1 and web0=1 (port idle). addr0, din0 and wmask0 hold their last values.
- FILL:
  - One write per cycle with no stall: din0=pattern, wmask0=all ones, same counter, remaining and words_written updates.
- Port-0 outputs are registered: one-cycle latency from handshake (or FILL step) to the write on the SRAM pins.
- Completion:
  - In the cycle the final write is on the pins, done=1.
  - State is IDLE in the following cycle, and busy falls with it.
  - A new cmd_valid is accepted in the first IDLE cycle.
- abort while busy:
  - Takes priority over a same-cycle handshake or FILL step; that word is not written.
  - Next cycle: csb0=1, web0=1, aborted=1, done=0, state IDLE.
  - words_written holds the count already issued.
  - abort in IDLE is ignored.
- Port 0 never reads: web0=1 whenever csb0=1. The block never drives csb0=0 with web0=1.
- Length 2^ADDR_WIDTH starting at a nonzero base wraps and covers every address exactly once.

Decomposition:
- Shared package holds:
  - state enum (IDLE, STREAM, FILL);
  - SRAM geometry constants (DATA_WIDTH, ADDR_WIDTH, NUM_WMASKS) used by this block and the port-1 reader wrapper;
  - SRAM_DEPTH = 2^ADDR_WIDTH.
- No sub-module: the FSM, address/remaining counters and port-0 output register are one flat block.

Test Plan:
- Stream, base=0x10, len=4, s_valid held high, data 0xA0..0xA3, mask 0xF:
  - writes to addr 0x10..0x13 on consecutive cycles, one cycle after each handshake;
  - done on the 4th write; words_written=4.
- Stream with s_valid toggling 1,0,1,1,0,1, len=4:
  - csb0=0 only in cycles after handshakes; data order preserved;
  - s_ready=0 after the 4th accept.
- Fill, base=0xFE, len=3, pattern 0xDEADBEEF:
  - writes at 0xFE, 0xFF, 0x00 with wmask0=0xF; done at the third.
- Fill, len=0:
  - exactly 256 writes covering all addresses; words_written=256.
  - A read-back through the port-1 reader returns the pattern for every word.
- Stream len=8, abort asserted after 3 handshakes, in the same cycle as the 4th handshake:
  - only 3 writes issued; aborted pulses; done never pulses; words_written=3.
- rst asserted mid-FILL (after 5 writes):
  - next cycle csb0=1, web0=1, busy=0, words_written=0;
  - a new command accepted right after rst deasserts.
